// File: rtl/hack_pkg.sv
// Shared definitions for the Hack bitwise logic unit: operation encodings
// and small elaboration-time helpers.
package hack_pkg;

  typedef enum logic [1:0] {
    HACK_OP_AND  = 2'b00,
    HACK_OP_OR   = 2'b01,
    HACK_OP_XOR  = 2'b10,
    HACK_OP_NAND = 2'b11
  } hack_op_e;

  // A one-entry buffer still needs a one-bit pointer to keep the vectors legal.
  function automatic int ptr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/hack_logic_unit_if.sv
// Operand/result handshake bundle of the Hack logic unit; the producer and
// consumer side share the master modport, the unit uses the slave modport.
interface hack_logic_unit_if
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  hack_op_e         op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zr, ng
  );

endinterface

// File: rtl/hack_logic_core.sv
// Purely combinational bitwise evaluator: result of op on a, b plus the
// zero and negative flags of that result.
module hack_logic_core
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  hack_op_e         op,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  // Bitwise operation select and flag derivation.
  always_comb begin
    case (op)
      HACK_OP_AND:  result = a & b;
      HACK_OP_OR:   result = a | b;
      HACK_OP_XOR:  result = a ^ b;
      HACK_OP_NAND: result = ~(a & b);
      default:      result = {WIDTH{1'b0}};
    endcase
    zr = (result == {WIDTH{1'b0}});
    ng = result[WIDTH-1];
  end

endmodule

// File: rtl/hack_logic_unit.sv
// Hack logic unit: evaluates accepted operand pairs and queues the results
// in a DEPTH-entry FIFO behind a valid/ready handshake on both sides.
module hack_logic_unit
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  hack_logic_unit_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] core_result_s;
  logic             core_zr_s;
  logic             core_ng_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_nxt_s;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic             zr_mem_r   [DEPTH];
  logic             ng_mem_r   [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  hack_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.a),
    .b      (bus.b),
    .op     (bus.op),
    .result (core_result_s),
    .zr     (core_zr_s),
    .ng     (core_ng_s)
  );

  // Handshake decode and next occupancy; readiness comes only from registers.
  always_comb begin
    push_s = bus.in_valid & in_ready_r;
    pop_s  = bus.out_ready & out_valid_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s < CNT_FULL);
      out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // Result storage; contents are only ever observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= core_result_s;
      zr_mem_r[wr_ptr_r]   <= core_zr_s;
      ng_mem_r[wr_ptr_r]   <= core_ng_s;
    end
  end

  // Head of queue, forced to the idle pattern so stale entries never leak out.
  always_comb begin
    if (out_valid_r) begin
      bus.out = data_mem_r[rd_ptr_r];
      bus.zr  = zr_mem_r[rd_ptr_r];
      bus.ng  = ng_mem_r[rd_ptr_r];
    end else begin
      bus.out = {WIDTH{1'b0}};
      bus.zr  = 1'b1;
      bus.ng  = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_hack_logic_unit.sv
// Self-checking bench for hack_logic_unit: directed vector table, stall and
// reset sequences, and a scoreboard-driven random handshake run.
module tb_hack_logic_unit;
  import hack_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hack_logic_unit_if #(.WIDTH(16)) bus16 ();
  hack_logic_unit_if #(.WIDTH(8))  bus8 ();

  hack_logic_unit #(.WIDTH(16), .DEPTH(2)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  hack_logic_unit #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    hack_op_e    op;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model built from per-op truth tables indexed by {a_bit, b_bit}.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input hack_op_e op);
    exp_t       e;
    logic [3:0] tt;
    case (op)
      HACK_OP_AND: tt = 4'b1000;
      HACK_OP_OR:  tt = 4'b1110;
      HACK_OP_XOR: tt = 4'b0110;
      default:     tt = 4'b0111;
    endcase
    for (int i = 0; i < 16; i++) e.out[i] = tt[{a[i], b[i]}];
    e.zr = (e.out == 16'h0000);
    e.ng = e.out[15];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input hack_op_e op);
    bus16.a  = a;
    bus16.b  = b;
    bus16.op = op;
  endtask

  task automatic drive_rand16();
    drive16(16'($urandom), 16'($urandom), hack_op_e'(2'($urandom_range(0, 3))));
  endtask

  // One clock of the scoreboarded run: check head, predict handshakes, advance.
  task automatic cycle16();
    logic do_push;
    logic do_pop;
    exp_t nxt;
    chk("sb_out_valid", 64'(bus16.out_valid), 64'(sbq.size() != 0));
    chk("sb_in_ready", 64'(bus16.in_ready), 64'(sbq.size() < 2));
    if (sbq.size() != 0) begin
      chk("sb_out", 64'(bus16.out), 64'(sbq[0].out));
      chk("sb_zr", 64'(bus16.zr), 64'(sbq[0].zr));
      chk("sb_ng", 64'(bus16.ng), 64'(sbq[0].ng));
    end
    do_pop  = bus16.out_ready && (sbq.size() != 0);
    do_push = bus16.in_valid && (sbq.size() < 2);
    nxt     = model(bus16.a, bus16.b, bus16.op);
    tick();
    if (do_pop) sbq.delete(0);
    if (do_push) sbq.push_back(nxt);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{16'hFFFF, 16'h0000, HACK_OP_AND,  16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'hAAAA, 16'h5555, HACK_OP_AND,  16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hAAAA, 16'h5555, HACK_OP_OR,   16'hFFFF, 1'b0, 1'b1};
    vecs[3] = '{16'hAAAA, 16'h5555, HACK_OP_XOR,  16'hFFFF, 1'b0, 1'b1};
    vecs[4] = '{16'hAAAA, 16'h5555, HACK_OP_NAND, 16'hFFFF, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h9876, HACK_OP_XOR,  16'h8A42, 1'b0, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00FF, HACK_OP_NAND, 16'hFFF0, 1'b0, 1'b1};

    reset           = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.out_ready  = 1'b0;
    bus8.a          = 8'h00;
    bus8.b          = 8'h00;
    bus8.op         = HACK_OP_AND;
    drive16(vecs[0].a, vecs[0].b, vecs[0].op);
    bus16.in_valid  = 1'b1;
    bus16.out_ready = 1'b1;

    // Held in reset across two edges with a pending operand pair.
    #12;
    chk("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    chk("rst_out", 64'(bus16.out), 64'd0);
    chk("rst_zr", 64'(bus16.zr), 64'd1);
    chk("rst_ng", 64'(bus16.ng), 64'd0);
    chk("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst8_zr", 64'(bus8.zr), 64'd1);
    #10;
    reset = 1'b0;

    // Directed vectors, one at a time into an empty FIFO.
    for (int i = 0; i < 7; i++) begin
      drive16(vecs[i].a, vecs[i].b, vecs[i].op);
      bus16.in_valid = 1'b1;
      chk("vec_in_ready", 64'(bus16.in_ready), 64'd1);
      tick();
      bus16.in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), 64'(bus16.out_valid), 64'd1);
      chk($sformatf("vec%0d_out", i), 64'(bus16.out), 64'(vecs[i].out));
      chk($sformatf("vec%0d_zr", i), 64'(bus16.zr), 64'(vecs[i].zr));
      chk($sformatf("vec%0d_ng", i), 64'(bus16.ng), 64'(vecs[i].ng));
      tick();
      chk($sformatf("vec%0d_drained", i), 64'(bus16.out_valid), 64'd0);
    end

    // Backpressure: two accepts fill the FIFO, third pair must wait.
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b1;
    drive16(16'h1234, 16'h9876, HACK_OP_AND);
    tick();
    drive16(16'h3CC3, 16'h0FF0, HACK_OP_OR);
    tick();
    chk("full_in_ready", 64'(bus16.in_ready), 64'd0);
    chk("full_head", 64'(bus16.out), 64'h1034);
    drive16(16'hFFFF, 16'hFFFF, HACK_OP_OR);
    tick();
    drive16(16'h1234, 16'h9876, HACK_OP_XOR);
    tick();
    chk("stall_in_ready", 64'(bus16.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus16.out_valid), 64'd1);
    chk("stall_head_stable", 64'(bus16.out), 64'h1034);
    bus16.out_ready = 1'b1;
    tick();
    chk("order_2nd", 64'(bus16.out), 64'h3FF3);
    chk("pop_in_ready", 64'(bus16.in_ready), 64'd1);
    tick();
    bus16.in_valid = 1'b0;
    chk("order_3rd", 64'(bus16.out), 64'h8A42);
    chk("order_3rd_ng", 64'(bus16.ng), 64'd1);
    tick();
    chk("order_empty", 64'(bus16.out_valid), 64'd0);

    // Scoreboarded run: fill, saturate both sides, then random stalls.
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b1;
    repeat (3) begin
      drive_rand16();
      cycle16();
    end
    bus16.out_ready = 1'b1;
    repeat (20) begin
      drive_rand16();
      cycle16();
    end
    repeat (300) begin
      drive_rand16();
      bus16.in_valid  = ($urandom_range(0, 3) != 0);
      bus16.out_ready = ($urandom_range(0, 2) != 0);
      cycle16();
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    k = 0;
    while (sbq.size() != 0 && k < 10) begin
      cycle16();
      k++;
    end
    cycle16();

    // Mid-cycle reset with two buffered entries discards them.
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b1;
    drive16(16'h8001, 16'hFFFF, HACK_OP_AND);
    tick();
    drive16(16'h0000, 16'h0000, HACK_OP_NAND);
    tick();
    bus16.in_valid = 1'b0;
    chk("pre_rst_in_ready", 64'(bus16.in_ready), 64'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus16.in_ready), 64'd1);
    chk("async_rst_out", 64'(bus16.out), 64'd0);
    chk("async_rst_zr", 64'(bus16.zr), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_out_valid%0d", i), 64'(bus16.out_valid), 64'd0);
      chk($sformatf("post_rst_in_ready%0d", i), 64'(bus16.in_ready), 64'd1);
    end

    // Narrow, deeper instance.
    bus8.a         = 8'h80;
    bus8.b         = 8'hFF;
    bus8.op        = HACK_OP_AND;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    chk("w8_out", 64'(bus8.out), 64'h80);
    chk("w8_ng", 64'(bus8.ng), 64'd1);
    chk("w8_zr", 64'(bus8.zr), 64'd0);
    tick();
    chk("w8_drained", 64'(bus8.out_valid), 64'd0);

    bus8.out_ready = 1'b0;
    bus8.op        = HACK_OP_OR;
    bus8.b         = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bus8.a        = 8'(i * 16 + 5);
      bus8.in_valid = 1'b1;
      chk($sformatf("w8_fill_ready%0d", i), 64'(bus8.in_ready), 64'd1);
      tick();
    end
    bus8.a = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w8_full_ready%0d", i), 64'(bus8.in_ready), 64'd0);
      tick();
    end
    chk("w8_full_head", 64'(bus8.out), 64'h05);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    chk("w8_first_pop_ready", 64'(bus8.in_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("w8_order%0d", i), 64'(bus8.out), 64'(8'(i * 16 + 5)));
      tick();
    end
    chk("w8_empty", 64'(bus8.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
